// File: rtl/rgmii_to_mii_axil_pkg.sv
// rtl/rgmii_to_mii_axil_pkg.sv - shared types and helpers for the rgmii_to_mii AXI4-Lite register slave
package rgmii_to_mii_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_DATA = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    // Word index of a byte address; the two byte-offset bits are dropped.
    function automatic logic [31:0] reg_index(input logic [31:0] addr);
        return {2'b00, addr[31:2]};
    endfunction

    // Merge new data into an old word, one byte lane per strobe bit.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old,
                                                 input logic [31:0] data,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = data[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rgmii_to_mii_axil_wr_fsm.sv
// rtl/rgmii_to_mii_axil_wr_fsm.sv - AW/W capture, commit strobe and B response engine
module rgmii_to_mii_axil_wr_fsm
    import rgmii_to_mii_axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    output logic                  commit,
    output logic                  commit_ok,
    output logic [31:0]           commit_index,
    output logic [31:0]           commit_data,
    output logic [3:0]            commit_strb
);

    wr_state_t             state, state_n;
    logic                  aw_held, aw_held_n;
    logic                  w_held, w_held_n;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  awready_n, wready_n;
    logic                  bvalid_n;
    logic [1:0]            bresp_n;
    logic                  aw_hs, w_hs;

    assign aw_hs        = awvalid && awready;
    assign w_hs         = wvalid && wready;
    assign commit_index = reg_index(32'(awaddr_q));
    assign commit_ok    = (commit_index < NUM_REGS);
    assign commit_data  = wdata_q;
    assign commit_strb  = wstrb_q;

    // State register, registered handshake outputs and payload holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= W_IDLE;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state   <= state_n;
            aw_held <= aw_held_n;
            w_held  <= w_held_n;
            awready <= awready_n;
            wready  <= wready_n;
            bvalid  <= bvalid_n;
            bresp   <= bresp_n;
            if (aw_hs) begin
                awaddr_q <= awaddr;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
        end
    end

    // Next-state logic; READYs are precomputed so they drop the cycle after each capture.
    always_comb begin
        state_n   = state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        bvalid_n  = bvalid;
        bresp_n   = bresp;
        commit    = 1'b0;
        case (state)
            W_IDLE: begin
                aw_held_n = aw_held || aw_hs;
                w_held_n  = w_held || w_hs;
                if (aw_held_n && w_held_n) begin
                    state_n = W_COMMIT;
                end
            end
            W_COMMIT: begin
                commit    = 1'b1;
                aw_held_n = 1'b0;
                w_held_n  = 1'b0;
                bvalid_n  = 1'b1;
                bresp_n   = commit_ok ? RESP_OKAY : RESP_SLVERR;
                state_n   = W_RESP;
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_n = 1'b0;
                    state_n  = W_IDLE;
                end
            end
            default: begin
                state_n = W_IDLE;
            end
        endcase
        awready_n = (state_n == W_IDLE) && !aw_held_n;
        wready_n  = (state_n == W_IDLE) && !w_held_n;
    end

endmodule

// File: rtl/rgmii_to_mii_axil_slave.sv
// rtl/rgmii_to_mii_axil_slave.sv - AXI4-Lite register file for the rgmii_to_mii core
module rgmii_to_mii_axil_slave
    import rgmii_to_mii_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    logic [31:0] regs [NUM_REGS];

    logic        commit;
    logic        commit_ok;
    logic [31:0] commit_index;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;

    rd_state_t                   rd_state, rd_state_n;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_q;
    logic                        arready_n;
    logic                        rvalid_n;
    logic [31:0]                 rdata_n;
    logic [1:0]                  rresp_n;
    logic [31:0]                 rd_index;
    logic                        rd_ok;
    logic [31:0]                 rd_word;

    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    rgmii_to_mii_axil_wr_fsm #(
        .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr_fsm (
        .clk          (S_AXI_ACLK),
        .rst          (S_AXI_ARESET),
        .awaddr       (S_AXI_AWADDR),
        .awvalid      (S_AXI_AWVALID),
        .awready      (S_AXI_AWREADY),
        .wdata        (S_AXI_WDATA),
        .wstrb        (S_AXI_WSTRB),
        .wvalid       (S_AXI_WVALID),
        .wready       (S_AXI_WREADY),
        .bresp        (S_AXI_BRESP),
        .bvalid       (S_AXI_BVALID),
        .bready       (S_AXI_BREADY),
        .commit       (commit),
        .commit_ok    (commit_ok),
        .commit_index (commit_index),
        .commit_data  (commit_data),
        .commit_strb  (commit_strb)
    );

    // Register array: byte-strobed update on an in-range commit.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && commit_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_index == 32'(i)) begin
                    regs[i] <= apply_wstrb(regs[i], commit_data, commit_strb);
                end
            end
        end
    end

    // Flat export of the register file plus the commit strobe (fires even for WSTRB=0).
    always_comb begin
        reg_q        = '0;
        reg_wr_pulse = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[32*i +: 32] = regs[i];
            reg_wr_pulse[i]   = commit && commit_ok && (commit_index == 32'(i));
        end
    end

    // Read-side word select from the latched AR address.
    always_comb begin
        rd_index = reg_index(32'(araddr_q));
        rd_ok    = (rd_index < NUM_REGS);
        rd_word  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_index == 32'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    // Read engine state register and registered R channel.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rd_state      <= R_IDLE;
            araddr_q      <= '0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= 2'b00;
        end else begin
            rd_state      <= rd_state_n;
            S_AXI_ARREADY <= arready_n;
            S_AXI_RVALID  <= rvalid_n;
            S_AXI_RDATA   <= rdata_n;
            S_AXI_RRESP   <= rresp_n;
            if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                araddr_q <= S_AXI_ARADDR;
            end
        end
    end

    // Read engine next state; sampling in R_DATA sees the pre-commit value of a same-cycle write.
    always_comb begin
        rd_state_n = rd_state;
        rvalid_n   = S_AXI_RVALID;
        rdata_n    = S_AXI_RDATA;
        rresp_n    = S_AXI_RRESP;
        case (rd_state)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    rd_state_n = R_DATA;
                end
            end
            R_DATA: begin
                rvalid_n   = 1'b1;
                rdata_n    = rd_ok ? rd_word : '0;
                rresp_n    = rd_ok ? RESP_OKAY : RESP_SLVERR;
                rd_state_n = R_RESP;
            end
            R_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_n   = 1'b0;
                    rd_state_n = R_IDLE;
                end
            end
            default: begin
                rd_state_n = R_IDLE;
            end
        endcase
        arready_n = (rd_state_n == R_IDLE);
    end

endmodule
